// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master among NREQ requesters; gnt/m_newd rise 1 clk after req is sampled in IDLE.
// Requesters hold req until their done/err pulse; the transfer is paced by m_cs and bounded by TIMEOUT per phase.
module spi_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          err,
  output logic                     m_newd,
  output logic [DW-1:0]            m_din,
  input  logic                     m_cs,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  cur_id
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, ACTIVE, DONE, ERR} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt, done_nxt, err_nxt;
  logic            m_newd_nxt;
  logic [DW-1:0]   m_din_nxt;
  logic [IW-1:0]   cur_id_nxt, rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   words [NREQ];
  logic            found;
  logic [IW-1:0]   pick, idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign words[g] = req_data[g*DW +: DW];
  end

  // First requester strictly after the last winner, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    done_nxt   = '0;
    err_nxt    = '0;
    m_newd_nxt = m_newd;
    m_din_nxt  = m_din;
    cur_id_nxt = cur_id;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = LAUNCH;
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          cur_id_nxt    = pick;
          m_din_nxt     = words[pick];
          m_newd_nxt    = 1'b1;
          cnt_nxt       = '0;
        end
      end
      LAUNCH: begin
        cnt_nxt = cnt + 1'b1;
        // A cs assertion on the terminal cycle still counts as a launch.
        if (!m_cs) begin
          state_nxt  = ACTIVE;
          m_newd_nxt = 1'b0;
          cnt_nxt    = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt       = ERR;
          m_newd_nxt      = 1'b0;
          err_nxt[cur_id] = 1'b1;
        end
      end
      ACTIVE: begin
        cnt_nxt = cnt + 1'b1;
        if (m_cs) begin
          state_nxt        = DONE;
          done_nxt[cur_id] = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt       = ERR;
          err_nxt[cur_id] = 1'b1;
        end
      end
      DONE, ERR: begin
        state_nxt  = IDLE;
        gnt_nxt    = '0;
        m_newd_nxt = 1'b0;
        rr_ptr_nxt = cur_id;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      err    <= '0;
      m_newd <= 1'b0;
      m_din  <= '0;
      cur_id <= '0;
      rr_ptr <= IW'(NREQ - 1);
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      m_newd <= m_newd_nxt;
      m_din  <= m_din_nxt;
      cur_id <= cur_id_nxt;
      rr_ptr <= rr_ptr_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: transaction-level reference model, per-cycle compare, literal spot checks.
module tb_spi_req_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 12;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt, done, err;
  logic              m_newd;
  logic [DW-1:0]     m_din;
  logic              m_cs;
  logic              busy;
  logic [1:0]        cur_id;

  logic              fm_en;
  logic              fm_cs;
  logic              cs_man;
  logic [DW-1:0]     fm_rx;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign m_cs = fm_en ? fm_cs : cs_man;

  spi_req_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .m_newd(m_newd), .m_din(m_din),
    .m_cs(m_cs), .busy(busy), .cur_id(cur_id)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction walk) ----------------
  logic [NREQ-1:0] e_gnt = '0, e_done = '0, e_err = '0;
  logic            e_newd = 1'b0;
  logic [DW-1:0]   e_din = '0;
  int              e_id = 0;
  int              e_ptr = NREQ - 1;

  task automatic m_reset();
    e_gnt = '0; e_done = '0; e_err = '0; e_newd = 1'b0;
    e_din = '0; e_id = 0; e_ptr = NREQ - 1;
  endtask

  task automatic m_step(output bit ab);
    @(posedge clk);
    ab = !rst;
    if (ab) m_reset();
  endtask

  task automatic m_txn(input int w);
    bit ab, launched, finished;
    e_gnt = '0; e_gnt[w] = 1'b1;
    e_id = w; e_din = req_data[w*DW +: DW]; e_newd = 1'b1;
    launched = 0; finished = 0;
    for (int n = 0; n < TIMEOUT; n++) begin
      m_step(ab); if (ab) return;
      if (!m_cs) begin launched = 1; break; end
    end
    e_newd = 1'b0;
    if (launched) begin
      for (int n = 0; n < TIMEOUT; n++) begin
        m_step(ab); if (ab) return;
        if (m_cs) begin finished = 1; break; end
      end
    end
    if (finished) e_done[w] = 1'b1; else e_err[w] = 1'b1;
    m_step(ab); if (ab) return;
    e_done = '0; e_err = '0; e_gnt = '0; e_ptr = w;
  endtask

  initial begin : model
    bit ab;
    int w;
    forever begin
      m_step(ab);
      if (!ab && req != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(e_ptr + k) % NREQ]) w = (e_ptr + k) % NREQ;
        m_txn(w);
      end
    end
  end

  // ---------------- spi_master stand-in ----------------
  initial begin : fake_master
    fm_cs = 1'b1;
    fm_rx = '0;
    forever begin
      @(negedge clk);
      if (fm_en && m_newd && rst) begin
        repeat (2) @(negedge clk);
        fm_cs = 1'b0;
        for (int b = 0; b < DW; b++) begin
          fm_rx = {m_din[b], fm_rx[DW-1:1]};
          @(negedge clk);
        end
        fm_cs = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int cyc = 0;
  int newd_run = 0, last_newd_run = 0;
  int done_cnt [NREQ];
  int err_cnt  [NREQ];
  int gq [$];
  logic [NREQ-1:0] gnt_q = '0;

  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc >= 1) begin
        chk("gnt",    gnt,    e_gnt);
        chk("done",   done,   e_done);
        chk("err",    err,    e_err);
        chk("m_newd", m_newd, e_newd);
        chk("m_din",  m_din,  e_din);
        chk("cur_id", cur_id, e_id);
        chk("busy",   busy,   e_gnt != '0);
        chk("gnt_onehot0", $onehot0(gnt), 1);
        chk("done_err_excl", (|done) && (|err), 0);
        chk("newd_implies_busy", m_newd && !busy, 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) done_cnt[i]++;
        if (err[i])  err_cnt[i]++;
      end
      if (gnt != '0 && gnt_q == '0) gq.push_back(int'(cur_id));
      gnt_q = gnt;
      if (m_newd) newd_run++;
      else begin
        if (newd_run != 0) last_newd_run = newd_run;
        newd_run = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && busy; i++) tick();
    chk(name, busy, 0);
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int d0, e0, tot;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    rst = 1'b0; req = '0; fm_en = 1'b1; cs_man = 1'b1;
    req_data = {12'h3C7, 12'hA5C, 12'h222, 12'h111};
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_newd", m_newd, 0);
    chk("rst_din", m_din, 0);
    chk("rst_cur_id", cur_id, 0);
    rst = 1'b1;
    tick();

    // round robin from reset: 0,1,2,3,0
    req = 4'b1111;
    for (int i = 0; i < 2000 && gq.size() < 5; i++) tick();
    req = '0;
    wait_idle("rr_idle");
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < gq.size()) ? gq[i] : -1, rr_exp[i]);

    // single requester 2
    req = 4'b0100;
    d0 = done_cnt[2];
    tick();
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_din", m_din, 12'hA5C);
    chk("t1_newd", m_newd, 1);
    for (int i = 0; i < 200 && done_cnt[2] == d0; i++) tick();
    chk("t1_done", done, 4'b0100);
    req = '0;
    tick();
    chk("t1_gnt_clear", gnt, 0);
    chk("t1_serial", fm_rx, 12'hA5C);
    wait_idle("t1_idle");

    // launch timeout on requester 1
    fm_en = 1'b0; cs_man = 1'b1;
    req = 4'b0010;
    e0 = err_cnt[1]; d0 = done_cnt[1];
    for (int i = 0; i < 1200 && err_cnt[1] == e0; i++) tick();
    req = '0;
    chk("t3_err_cnt", err_cnt[1] - e0, 1);
    chk("t3_newd_run", last_newd_run, 1024);
    chk("t3_no_done", done_cnt[1] - d0, 0);
    wait_idle("t3_idle");

    // cs arriving on the terminal LAUNCH cycle wins over timeout
    req = 4'b0001;
    tick();
    chk("prec_gnt", gnt, 4'b0001);
    repeat (TIMEOUT - 1) tick();
    cs_man = 1'b0;
    tick();
    chk("prec_err", err, 0);
    chk("prec_newd", m_newd, 0);
    chk("prec_busy", busy, 1);
    cs_man = 1'b1;
    tick();
    chk("prec_done", done, 4'b0001);
    req = '0;
    wait_idle("prec_idle");
    fm_en = 1'b1;

    // requester 3 drops req mid-transfer; its word must stay on m_din
    req = 4'b1000;
    d0 = done_cnt[3];
    for (int i = 0; i < 100 && !(gnt[3] && !m_cs); i++) tick();
    tick();
    req = '0;
    req_data[3*DW +: DW] = 12'hFFF;
    for (int i = 0; i < 200 && done_cnt[3] == d0; i++) tick();
    chk("t4_done", done_cnt[3] - d0, 1);
    chk("t4_din", m_din, 12'h3C7);
    wait_idle("t4_idle");
    req_data[3*DW +: DW] = 12'h3C7;

    // wrap: last winner 3, req {3,0}: 0 is next after wrap
    req = 4'b1001;
    tick();
    chk("wrap_gnt", gnt, 4'b0001);
    for (int i = 0; i < 200 && done == '0; i++) tick();
    req = '0;
    wait_idle("wrap_idle");

    // skip: last winner 0, req {3,0}: scan 1,2,3 picks 3
    req = 4'b1001;
    tick();
    chk("skip_gnt", gnt, 4'b1000);
    for (int i = 0; i < 200 && done == '0; i++) tick();
    req = '0;
    wait_idle("skip_idle");

    // reset during ACTIVE
    req = 4'b1111;
    for (int i = 0; i < 100 && !(busy && !m_cs); i++) tick();
    tick();
    tot = 0;
    for (int i = 0; i < NREQ; i++) tot += done_cnt[i] + err_cnt[i];
    rst = 1'b0;
    tick();
    chk("t5_gnt", gnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_newd", m_newd, 0);
    chk("t5_done_err", {done, err}, 0);
    chk("t5_cur_id", cur_id, 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < NREQ; i++) tot -= done_cnt[i] + err_cnt[i];
    chk("t5_no_pulse", tot, 0);
    chk("t5_first_gnt", gnt, 4'b0001);
    for (int i = 0; i < 200 && done == '0; i++) tick();
    req = '0;
    wait_idle("t5_idle");

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
